// File: rtl/msg_relay_fifo.sv
`default_nettype none
// ============================================================================
// Module   : msg_relay_fifo
// Purpose  : Multi-channel message relay. NUM_CH blocking sync/notify input
//            channels are arbitrated round-robin into a DEPTH-entry FIFO and
//            emitted on a single blocking sync/notify output channel.
//            Messages are {mode, y, x}; mode read=0, write=1. A write-mode
//            message with y=1 is a flush marker: it is enqueued, then input
//            acceptance stops until the FIFO has drained.
// Ports    : clk        - clock
//            rst        - asynchronous active-high reset
//            in_msg     - channel i message at [i*MSG_W +: MSG_W]
//            in_sync    - channel i offers a message
//            in_notify  - one-hot accept grant (combinational)
//            out_msg    - FIFO head message (0 when empty)
//            out_sync   - consumer takes out_msg this cycle
//            out_notify - out_msg is valid
//            occupancy  - entries currently stored
//            drain_busy - block is draining after a flush marker
//            accept_cnt - per-channel 16-bit accept counters
//                         (only when MSG_RELAY_STATS_EN is defined)
// Config   : MSG_RELAY_STATS_EN - adds the accept_cnt port and counters
// Revision : 1.0 - initial release
// ============================================================================
module msg_relay_fifo #(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 8,
   localparam int MSG_W  = DATA_W + 2,
   localparam int OCC_W  = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH*MSG_W-1:0] in_msg,
   input  logic [NUM_CH-1:0]       in_sync,
   output logic [NUM_CH-1:0]       in_notify,
   output logic [MSG_W-1:0]        out_msg,
   input  logic                    out_sync,
   output logic                    out_notify,
   output logic [OCC_W-1:0]        occupancy,
   output logic                    drain_busy
`ifdef MSG_RELAY_STATS_EN
   ,
   output logic [NUM_CH*16-1:0]    accept_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CH_W-1:0]     rr_ptr;
   logic [CH_W-1:0]     rr_nxt;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [MSG_W-1:0]    mem [DEPTH];
   logic                grant_found;
   logic [CH_W-1:0]     grant_idx;
   logic                can_accept;
   logic                push;
   logic                pop;
   logic [MSG_W-1:0]    push_msg;
   logic                is_marker;

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_CH.
   always_comb begin
      logic [CH_W:0] cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = {1'b0, rr_ptr} + (CH_W+1)'(k);
         if (cand >= (CH_W+1)'(NUM_CH)) begin
            cand = cand - (CH_W+1)'(NUM_CH);
         end
         if (!grant_found && in_sync[cand[CH_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[CH_W-1:0];
         end
      end
   end

   // Grant is withheld during reset so no transfer can be seen while rst=1.
   always_comb begin
      in_notify = '0;
      if (!rst && can_accept && grant_found) begin
         in_notify[grant_idx] = 1'b1;
      end
   end

   assign push      = |(in_sync & in_notify);
   assign push_msg  = in_msg[int'(grant_idx)*MSG_W +: MSG_W];
   assign is_marker = push_msg[MSG_W-1] & push_msg[MSG_W-2];
   assign rr_nxt    = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

   assign out_notify = (occupancy != '0);
   assign pop        = out_notify & out_sync;
   assign out_msg    = out_notify ? mem[rd_ptr] : '0;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and outputs. A full FIFO blocks grants even when a pop
   // happens in the same cycle; there is no full-bypass.
   always_comb begin
      state_nxt  = state;
      can_accept = 1'b0;
      drain_busy = 1'b0;
      case (state)
         RUN: begin
            can_accept = (occupancy != OCC_W'(DEPTH));
            if (push && is_marker) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            drain_busy = 1'b1;
            if (occupancy == '0) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // Pointers, arbitration pointer and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            rr_ptr <= rr_nxt;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Storage needs no reset: out_msg is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_msg;
      end
   end

`ifdef MSG_RELAY_STATS_EN
   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_stats
         logic [15:0] cnt;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt <= '0;
            end else if (in_sync[c] && in_notify[c]) begin
               cnt <= cnt + 16'd1;
            end
         end
         assign accept_cnt[c*16 +: 16] = cnt;
      end
   endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_msg_relay_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_relay_fifo
// Purpose  : Self-checking bench for msg_relay_fifo (NUM_CH=4, DATA_W=32,
//            DEPTH=8). A vector table drives the main sequences; a queue
//            scoreboard with a small arbitration model tracks expected output
//            messages, grants, occupancy and drain state every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_relay_fifo;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int MSG_W  = DATA_W + 2;
   localparam int OCC_W  = $clog2(DEPTH + 1);
   localparam int NVEC   = 33;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH*MSG_W-1:0] in_msg;
   logic [NUM_CH-1:0]       in_sync;
   logic [NUM_CH-1:0]       in_notify;
   logic [MSG_W-1:0]        out_msg;
   logic                    out_sync;
   logic                    out_notify;
   logic [OCC_W-1:0]        occupancy;
   logic                    drain_busy;
`ifdef MSG_RELAY_STATS_EN
   logic [NUM_CH*16-1:0]    accept_cnt;
`endif

   msg_relay_fifo #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_msg     (in_msg),
      .in_sync    (in_sync),
      .in_notify  (in_notify),
      .out_msg    (out_msg),
      .out_sync   (out_sync),
      .out_notify (out_notify),
      .occupancy  (occupancy),
      .drain_busy (drain_busy)
`ifdef MSG_RELAY_STATS_EN
      ,
      .accept_cnt (accept_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] s;    // in_sync
      logic       os;   // out_sync
      int         mk;   // channel carrying a flush marker, -1 for none
      logic [3:0] en;   // expected in_notify during the cycle
      logic       ed;   // expected drain_busy during the cycle
      int         eo;   // expected occupancy after the edge
   } vec_t;

   vec_t             vecs[NVEC];
   logic [MSG_W-1:0] sb[$];
   int               m_rr;
   bit               m_drain;
   int               m_cnt[NUM_CH];
   int               checks = 0;
   int               errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [MSG_W-1:0] make_msg(input int ch, input int tag, input int mk);
      if (ch == mk) return {1'b1, 1'b1, 32'hA};
      return {1'b0, 1'b0, 32'(tag * 16 + ch)};
   endfunction

   task automatic model_reset();
      sb.delete();
      m_rr    = 0;
      m_drain = 1'b0;
      for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
   endtask

   // Called at posedge+1: drive, check mid-cycle against the model, advance.
   task automatic step(input logic [3:0] s, input logic os, input int mk, input int tag,
                       output logic [3:0] obs_n, output logic obs_d);
      logic [MSG_W-1:0] msgs[NUM_CH];
      logic [MSG_W-1:0] popped;
      logic             found;
      logic             was_empty;
      logic [3:0]       en;
      int               g;
      for (int c = 0; c < NUM_CH; c++) begin
         msgs[c] = make_msg(c, tag, mk);
         in_msg[c*MSG_W +: MSG_W] = msgs[c];
      end
      in_sync  = s;
      out_sync = os;
      #2;
      found = 1'b0;
      g     = 0;
      if (!m_drain && sb.size() < DEPTH) begin
         for (int k = 0; k < NUM_CH; k++) begin
            int idx;
            idx = (m_rr + k) % NUM_CH;
            if (!found && s[idx]) begin
               found = 1'b1;
               g     = idx;
            end
         end
      end
      en = found ? 4'(1 << g) : 4'b0000;
      chk("in_notify",  64'(in_notify),  64'(en));
      chk("out_notify", 64'(out_notify), 64'(sb.size() != 0));
      chk("occupancy",  64'(occupancy),  64'(sb.size()));
      chk("drain_busy", 64'(drain_busy), 64'(m_drain));
      if (sb.size() != 0) chk("out_msg", 64'(out_msg), 64'(sb[0]));
      obs_n = in_notify;
      obs_d = drain_busy;
      was_empty = (sb.size() == 0);
      if (!was_empty && os) popped = sb.pop_front();
      if (found) begin
         sb.push_back(msgs[g]);
         m_rr = (g + 1) % NUM_CH;
         m_cnt[g]++;
      end
      if (m_drain && was_empty) m_drain = 1'b0;
      if (found && msgs[g][MSG_W-1] && msgs[g][MSG_W-2]) m_drain = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      logic [3:0] on;
      logic       od;

      // single accept, visibility, pop
      vecs[0]  = '{4'b0010, 1'b0, -1, 4'b0010, 1'b0, 1};
      vecs[1]  = '{4'b0000, 1'b0, -1, 4'b0000, 1'b0, 1};
      vecs[2]  = '{4'b0000, 1'b1, -1, 4'b0000, 1'b0, 0};
      // bring rr_ptr back to 0
      vecs[3]  = '{4'b1000, 1'b0, -1, 4'b1000, 1'b0, 1};
      vecs[4]  = '{4'b0000, 1'b1, -1, 4'b0000, 1'b0, 0};
      // all channels requesting: ch0..ch3 twice, FIFO fills
      for (int i = 5; i < 13; i++) vecs[i] = '{4'b1111, 1'b0, -1, 4'(1 << ((i - 5) % 4)), 1'b0, i - 4};
      vecs[13] = '{4'b1111, 1'b0, -1, 4'b0000, 1'b0, 8};
      // full with pop: no accept, then accept next cycle
      vecs[14] = '{4'b1111, 1'b1, -1, 4'b0000, 1'b0, 7};
      vecs[15] = '{4'b1111, 1'b0, -1, 4'b0001, 1'b0, 8};
      for (int i = 16; i < 24; i++) vecs[i] = '{4'b0000, 1'b1, -1, 4'b0000, 1'b0, 23 - i};
      // two queued, then flush marker on ch2
      vecs[24] = '{4'b0001, 1'b0, -1, 4'b0001, 1'b0, 1};
      vecs[25] = '{4'b0001, 1'b0, -1, 4'b0001, 1'b0, 2};
      vecs[26] = '{4'b0100, 1'b0,  2, 4'b0100, 1'b0, 3};
      vecs[27] = '{4'b1111, 1'b1, -1, 4'b0000, 1'b1, 2};
      vecs[28] = '{4'b1111, 1'b1, -1, 4'b0000, 1'b1, 1};
      vecs[29] = '{4'b1111, 1'b1, -1, 4'b0000, 1'b1, 0};
      vecs[30] = '{4'b1111, 1'b0, -1, 4'b0000, 1'b1, 0};
      vecs[31] = '{4'b1111, 1'b0, -1, 4'b1000, 1'b0, 1};
      vecs[32] = '{4'b0000, 1'b1, -1, 4'b0000, 1'b0, 0};

      rst      = 1'b1;
      in_sync  = 4'b1111;
      out_sync = 1'b0;
      in_msg   = '0;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_in_notify",  64'(in_notify),  64'(0));
      chk("rst_occupancy",  64'(occupancy),  64'(0));
      chk("rst_out_notify", 64'(out_notify), 64'(0));
      chk("rst_drain_busy", 64'(drain_busy), 64'(0));
      chk("rst_out_msg",    64'(out_msg),    64'(0));
      rst     = 1'b0;
      in_sync = 4'b0000;

      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].s, vecs[i].os, vecs[i].mk, i, on, od);
         chk($sformatf("v%0d_notify", i), 64'(on), 64'(vecs[i].en));
         chk($sformatf("v%0d_drain", i),  64'(od), 64'(vecs[i].ed));
         chk($sformatf("v%0d_occ", i),    64'(occupancy), 64'(vecs[i].eo));
      end

      // reset while draining with 5 entries held
      for (int i = 0; i < 4; i++) step(4'b1111, 1'b0, -1, 40 + i, on, od);
      step(4'b0010, 1'b0, 1, 44, on, od);
      step(4'b1111, 1'b0, -1, 45, on, od);
      chk("pre_rst_occ",   64'(occupancy),  64'(5));
      chk("pre_rst_drain", 64'(drain_busy), 64'(1));
      rst = 1'b1;
      #1;
      chk("async_rst_in_notify",  64'(in_notify),  64'(0));
      chk("async_rst_occupancy",  64'(occupancy),  64'(0));
      chk("async_rst_out_notify", 64'(out_notify), 64'(0));
      chk("async_rst_drain_busy", 64'(drain_busy), 64'(0));
      chk("async_rst_out_msg",    64'(out_msg),    64'(0));
      @(posedge clk);
      #1;
      chk("held_rst_in_notify", 64'(in_notify), 64'(0));
      rst = 1'b0;
      model_reset();
`ifdef MSG_RELAY_STATS_EN
      chk("rst_accept_cnt", 64'(accept_cnt), 64'(0));
`endif
      step(4'b0100, 1'b0, -1, 50, on, od);
      chk("post_rst_grant", 64'(on), 64'(4'b0100));
      step(4'b0000, 1'b1, -1, 51, on, od);
      chk("post_rst_occ", 64'(occupancy), 64'(0));
`ifdef MSG_RELAY_STATS_EN
      for (int c = 0; c < NUM_CH; c++) begin
         chk($sformatf("accept_cnt%0d", c), 64'(accept_cnt[c*16 +: 16]), 64'(16'(m_cnt[c])));
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
